// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package shared_reg_arbiter_pkg;

  localparam int MAX_NREQ = 16;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // One-hot vector with bit idx set; bits at or above n are always clear.
  function automatic logic [MAX_NREQ-1:0] onehot(input int idx, input int n);
    logic [MAX_NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (i == idx && i < n) v[i] = 1'b1;
    end
    return v;
  endfunction

  // (a + b) mod n for a, b already below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin priority picker: first set request at or after ptr.
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] winner,
  output logic            valid
);

  logic [IDXW-1:0] idx;

  // Scan from farthest to nearest so the request closest to ptr wins last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDXW'(wrap_add(int'(ptr), k, NREQ));
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register,
// with bounded lock bursts for a single owner.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [NREQ-1:0]                         REQ,
  input  logic [NREQ-1:0]                         LOCK,
  input  logic [NREQ*WIDTH-1:0]                   D,
  output logic [WIDTH-1:0]                        Q,
  output logic [NREQ-1:0]                         GNT,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] OWNER,
  output logic                                    BUSY
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(MAX_LOCK);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_LOCK - 1);

  state_t              state, state_nxt;
  logic [IDXW-1:0]     ptr, ptr_nxt;
  logic [CNTW-1:0]     cnt, cnt_nxt;
  logic [WIDTH-1:0]    q_nxt;
  logic [NREQ-1:0]     gnt_nxt;
  logic [IDXW-1:0]     owner_nxt;
  logic [IDXW-1:0]     win;
  logic                win_vld;
  logic [MAX_NREQ-1:0] oh;
  logic [WIDTH-1:0]    d_arr [NREQ];

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req    (REQ),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_vld)
  );

  // Split the flat data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) d_arr[i] = D[i*WIDTH +: WIDTH];
  end

  // Next-state, data mux and grant decode.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    q_nxt     = Q;
    gnt_nxt   = '0;
    owner_nxt = OWNER;
    oh        = '0;
    case (state)
      ARB: begin
        if (win_vld) begin
          oh        = onehot(int'(win), NREQ);
          q_nxt     = d_arr[win];
          gnt_nxt   = oh[NREQ-1:0];
          owner_nxt = win;
          ptr_nxt   = IDXW'(wrap_add(int'(win), 1, NREQ));
          if (LOCK[win]) begin
            state_nxt = LOCKED;
            cnt_nxt   = '0;
          end
        end
      end
      LOCKED: begin
        // Only the owner is served; everyone else waits for the exit.
        if (REQ[OWNER]) begin
          oh      = onehot(int'(OWNER), NREQ);
          q_nxt   = d_arr[OWNER];
          gnt_nxt = oh[NREQ-1:0];
        end
        if (!LOCK[OWNER] || cnt == CNT_LAST) begin
          // Pointer moves past the owner so a forced exit demotes it.
          state_nxt = ARB;
          ptr_nxt   = IDXW'(wrap_add(int'(OWNER), 1, NREQ));
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // State, pointer, lock counter and the shared data register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ARB;
      ptr   <= '0;
      cnt   <= '0;
      Q     <= '0;
      GNT   <= '0;
      OWNER <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      Q     <= q_nxt;
      GNT   <= gnt_nxt;
      OWNER <= owner_nxt;
    end
  end

  assign BUSY = (state == LOCKED);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized and directed bench for shared_reg_arbiter with a behavioural model.
module tb_shared_reg_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_LOCK = 8;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [NREQ-1:0]       REQ = '0;
  logic [NREQ-1:0]       LOCK = '0;
  logic [NREQ*WIDTH-1:0] D = '0;
  logic [WIDTH-1:0]      Q;
  logic [NREQ-1:0]       GNT;
  logic [1:0]            OWNER;
  logic                  BUSY;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0]  m_gnt;
  logic [1:0]       m_owner;
  logic             m_busy;
  int               m_ptr;
  int               m_cnt;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_LOCK(MAX_LOCK)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .LOCK  (LOCK),
    .D     (D),
    .Q     (Q),
    .GNT   (GNT),
    .OWNER (OWNER),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    m_q = '0; m_gnt = '0; m_owner = '0; m_busy = 1'b0; m_ptr = 0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    int  w;
    bit  found;
    int  o;
    found = 1'b0;
    w = 0;
    m_gnt = '0;
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && REQ[(m_ptr + k) % NREQ]) begin
          found = 1'b1;
          w = (m_ptr + k) % NREQ;
        end
      end
      if (found) begin
        m_q = D[w*WIDTH +: WIDTH];
        m_gnt[w] = 1'b1;
        m_owner = 2'(w);
        m_ptr = (w + 1) % NREQ;
        if (LOCK[w]) begin
          m_busy = 1'b1;
          m_cnt = 0;
        end
      end
    end else begin
      o = int'(m_owner);
      if (REQ[o]) begin
        m_q = D[o*WIDTH +: WIDTH];
        m_gnt[o] = 1'b1;
      end
      if (!LOCK[o] || m_cnt == MAX_LOCK - 1) begin
        m_busy = 1'b0;
        m_ptr = (o + 1) % NREQ;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  // One clock edge: model advances on the same sampled inputs, outputs read 1 time unit later.
  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    REQ = '0;
    LOCK = '0;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    REQ = 4'b1111;
    LOCK = '0;
    D = 32'hFFFF_FFFF;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", Q); end
    total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", GNT); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d want=0", OWNER); end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    step();
    total++; if (GNT !== 4'b0001 || Q !== 8'hFF) begin
      bad++; $display("FAIL reset_first_grant got gnt=%b q=%h want gnt=0001 q=ff", GNT, Q);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] eg;
    logic [WIDTH-1:0] eq;
    do_reset();
    D = 32'h43_32_21_10;
    REQ = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      eg = 4'b0001 << (k % 4);
      eq = 8'(8'h10 + 8'h11 * (k % 4));
      total++; if (GNT !== eg || Q !== eq || m_gnt !== eg) begin
        bad++; $display("FAIL rr_cycle%0d got gnt=%b q=%h want gnt=%b q=%h", k, GNT, Q, eg, eq);
      end
    end
  endtask

  task automatic test_lock();
    logic [NREQ-1:0] eg;
    do_reset();
    D = 32'hD3_C2_B1_A0;
    REQ = 4'b0001;
    step();
    REQ = 4'b0101;
    LOCK = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (GNT !== 4'b0100 || BUSY !== 1'b1 || Q !== 8'hC2) begin
        bad++; $display("FAIL lock_hold%0d got gnt=%b busy=%b q=%h want gnt=0100 busy=1 q=c2", k, GNT, BUSY, Q);
      end
    end
    REQ = 4'b0001;
    LOCK = 4'b0000;
    step();
    total++; if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
      bad++; $display("FAIL lock_exit got gnt=%b busy=%b want gnt=0000 busy=0", GNT, BUSY);
    end
    step();
    eg = 4'b0001;
    total++; if (GNT !== eg || Q !== 8'hA0 || m_gnt !== eg) begin
      bad++; $display("FAIL lock_after got gnt=%b q=%h want gnt=0001 q=a0", GNT, Q);
    end
  endtask

  task automatic test_forced_exit();
    logic [NREQ-1:0] eg;
    logic            eb;
    do_reset();
    D = 32'h33_22_11_00;
    REQ = 4'b1010;
    LOCK = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      step();
      eg = ((k % 10) == 9) ? 4'b1000 : 4'b0010;
      eb = ((k % 10) < 8);
      total++; if (GNT !== eg || BUSY !== eb || {m_gnt, m_busy} !== {eg, eb}) begin
        bad++; $display("FAIL forced_exit%0d got gnt=%b busy=%b want gnt=%b busy=%b", k, GNT, BUSY, eg, eb);
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    D = 32'h44_33_22_11;
    REQ = 4'b0010;
    LOCK = 4'b0010;
    repeat (4) step();
    #2;
    RST = 1'b1;
    #1;
    total++; if (Q !== 8'h00 || BUSY !== 1'b0 || GNT !== 4'b0000 || OWNER !== 2'd0) begin
      bad++; $display("FAIL midlock_reset got q=%h busy=%b gnt=%b owner=%0d want 00/0/0000/0", Q, BUSY, GNT, OWNER);
    end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    REQ = 4'b1111;
    LOCK = 4'b0000;
    step();
    total++; if (GNT !== 4'b0001 || Q !== 8'h11) begin
      bad++; $display("FAIL midlock_next got gnt=%b q=%h want gnt=0001 q=11", GNT, Q);
    end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] v;
    do_reset();
    REQ = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      v = (k % 2 == 0) ? 8'hA5 : 8'h5A;
      D = {v, 24'h0};
      step();
      total++; if (GNT !== 4'b1000 || Q !== v) begin
        bad++; $display("FAIL single%0d got gnt=%b q=%h want gnt=1000 q=%h", k, GNT, Q, v);
      end
      D = {~v, 24'hFFFFFF};
      #3;
      total++; if (Q !== v) begin
        bad++; $display("FAIL single_hold%0d got q=%h want q=%h", k, Q, v);
      end
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      REQ = NREQ'($urandom);
      LOCK = NREQ'($urandom & $urandom);
      D = $urandom;
      step();
      total++; if ({Q, GNT, OWNER, BUSY} !== {m_q, m_gnt, m_owner, m_busy}) begin
        bad++; errs++;
        if (errs < 10)
          $display("FAIL random%0d got q=%h gnt=%b own=%0d busy=%b want q=%h gnt=%b own=%0d busy=%b",
                   k, Q, GNT, OWNER, BUSY, m_q, m_gnt, m_owner, m_busy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_lock();
    test_forced_exit();
    test_reset_mid_lock();
    test_single();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin write arbiter that shares one WIDTH-bit data register among NREQ requesters. Each requester presents a write request with data. The arbiter grants one writer per cycle, loads the register, and acknowledges the winner with a one-cycle grant pulse. A requester may lock the register for a bounded burst of consecutive writes. The block sits in front of the datapath's shared state flops and replaces ad-hoc muxing into a single reset-able DFF.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16, not required to be a power of two)
- WIDTH, 8, register data width
- MAX_LOCK, 8, maximum consecutive cycles one requester may hold the lock (≥2)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, asynchronous, active-high
- REQ  in  NREQ  per-requester write request
- LOCK  in  NREQ  per-requester lock request; only meaningful together with REQ
- D  in  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH]
- Q  out  WIDTH  shared register value
- GNT  out  NREQ  one-hot write acknowledge, one cycle per accepted write
- OWNER  out  max(1,$clog2(NREQ))  index of the last accepted writer
- BUSY  out  1  high while in LOCKED state

## Operation
- Reset (async, while RST=1): Q=0, GNT=0, OWNER=0, BUSY=0, state=ARB, rr pointer=0, lock_cnt=0.
  - Reset asserted mid-lock aborts the lock immediately; no write completes at that edge.
- States: ARB, LOCKED.
- ARB state:
  - Winner = first i with REQ[i]=1, searching from the pointer upward and wrapping NREQ-1 to 0.
  - At the edge with any REQ high:
    - Q <= D[winner]
    - GNT <= onehot(winner)
    - OWNER <= winner
    - pointer <= (winner+1) mod NREQ
  - If LOCK[winner]=1 at that edge: state -> LOCKED, lock_cnt <= 0.
  - No REQ: Q holds, GNT=0, pointer holds.
  - LOCK without REQ is ignored.
- LOCKED state:
  - Only OWNER is served. REQ/LOCK from other requesters are ignored; they wait.
  - Each edge:
    - If REQ[OWNER]=1: Q <= D[OWNER] and GNT[OWNER] pulses.
    - lock_cnt increments.
  - Exit to ARB at the same edge when LOCK[OWNER]=0 or lock_cnt==MAX_LOCK-1.
    - The write at that edge still completes.
    - pointer <= (OWNER+1) mod NREQ.
  - A forced exit leaves the former owner with lowest priority. It wins again only if no other REQ is high.
- BUSY = (state==LOCKED), registered.
- Q changes only at CLK posedge or on RST assertion; never combinationally from D.

## Timing
- Write latency 1 cycle: REQ/D sampled at edge k; Q and GNT valid after edge k, for one cycle.
- GNT is a pulse. A requester holding REQ high after its GNT re-enters arbitration; under contention it is not re-granted before all other requesters are served once.
- Lock entry:
  - Edge k: write accepted with LOCK high.
  - BUSY goes high after edge k.
- Lock occupancy: LOCKED spans at most MAX_LOCK cycles, after which BUSY=0 for at least the next cycle's arbitration.
- Simultaneous LOCK deassert and lock_cnt==MAX_LOCK-1: single exit, identical behaviour.
- Throughput: one write per cycle, sustained.

## Structure
- Package shared_reg_arbiter_pkg holds:
  - the state enum (ARB, LOCKED)
  - a function onehot(idx, n)
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: REQ vector and pointer.
  - Outputs: winner index and a valid flag.
  - Reusable by other arbiters.
- Top holds the state register, pointer, lock_cnt and the data register with its data mux.

## Test plan
1. Reset while REQ=4'b1111, D all 0xFF, then release RST -> during reset Q=0x00, GNT=0, BUSY=0; first edge after release grants requester 0, Q=D[0].
2. REQ=4'b1111 held for 8 cycles, distinct data per requester -> GNT sequence 0,1,2,3,0,1,2,3; Q tracks the matching D each cycle.
3. REQ[2]=1 and LOCK[2]=1 for 3 cycles while REQ[0]=1 -> GNT[2] pulses 3 times, BUSY=1, GNT[0] stays 0; after LOCK[2] drops, requester 0 is granted next.
4. LOCK[1] and REQ[1] held for 20 cycles, MAX_LOCK=8, REQ[3]=1 -> forced exit after 8 LOCKED cycles, then GNT[3]; requester 1 is re-granted only afterward.
5. RST pulsed mid-lock (lock_cnt=3) -> Q=0, BUSY=0, pointer=0 immediately; the next grant follows the priority order from 0.
6. Single requester REQ[3]=1 with D cycling 0xA5, 0x5A -> GNT[3] every cycle; Q follows D with 1-cycle latency and never changes between edges.
